// File: rtl/tx_rx_receiver_if.sv
// rtl/tx_rx_receiver_if.sv - link and result signals between the transmitter side and the serial receiver
interface tx_rx_receiver_if #(
    parameter int DATA_W = 10,
    parameter int CNT_W  = 8
);
    logic              i_rx_ena_n;
    logic              i_serial;
    logic              i_tx_done;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              o_frame_err;
    logic              o_busy;
    logic [CNT_W-1:0]  o_frame_cnt;

    // Driving side: start strobe, serial line and done marker out, results in
    modport master (
        output i_rx_ena_n,
        output i_serial,
        output i_tx_done,
        input  o_data,
        input  o_valid,
        input  o_frame_err,
        input  o_busy,
        input  o_frame_cnt
    );

    // Receiver side
    modport slave (
        input  i_rx_ena_n,
        input  i_serial,
        input  i_tx_done,
        output o_data,
        output o_valid,
        output o_frame_err,
        output o_busy,
        output o_frame_cnt
    );
endinterface

// File: rtl/tx_rx_receiver.sv
// rtl/tx_rx_receiver.sv - LSB-first serial frame receiver with done-pulse framing check and good-frame counter
module tx_rx_receiver #(
    parameter int DATA_W = 10,
    parameter int CNT_W  = 8
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    tx_rx_receiver_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        SHIFT = 2'd2
    } state_t;

    // bit_cnt value at the edge that samples the final bit of a frame
    localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

    state_t            state;
    logic [3:0]        bit_cnt;
    logic [DATA_W-1:0] sreg;
    logic [DATA_W-1:0] shifted;

    // Shift register contents including the bit sampled at this edge
    assign shifted = {bus.i_serial, sreg[DATA_W-1:1]};

    // Frame FSM: all outputs registered; valid/err are single-cycle pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= IDLE;
            bit_cnt         <= '0;
            sreg            <= '0;
            bus.o_data      <= '0;
            bus.o_valid     <= 1'b0;
            bus.o_frame_err <= 1'b0;
            bus.o_busy      <= 1'b0;
            bus.o_frame_cnt <= '0;
        end else begin
            bus.o_valid     <= 1'b0;
            bus.o_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.i_rx_ena_n) begin
                        state      <= ALIGN;
                        bus.o_busy <= 1'b1;
                    end
                end
                // One dead cycle while the transmitter loads its word
                ALIGN: begin
                    state   <= SHIFT;
                    bit_cnt <= '0;
                end
                SHIFT: begin
                    sreg    <= shifted;
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == LAST_BIT) begin
                        if (bus.i_tx_done) begin
                            bus.o_data      <= shifted;
                            bus.o_valid     <= 1'b1;
                            bus.o_frame_cnt <= bus.o_frame_cnt + CNT_W'(1);
                        end else begin
                            bus.o_frame_err <= 1'b1;
                        end
                        // A strobe on the last-sample edge chains the next frame with no gap
                        if (!bus.i_rx_ena_n) begin
                            state <= ALIGN;
                        end else begin
                            state      <= IDLE;
                            bus.o_busy <= 1'b0;
                        end
                    end else if (bus.i_tx_done) begin
                        // Done arrived before the last bit: frame is short, drop it
                        bus.o_frame_err <= 1'b1;
                        state           <= IDLE;
                        bus.o_busy      <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    bus.o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_rx_receiver.sv
// tb/tb_tx_rx_receiver.sv - directed self-checking bench for tx_rx_receiver
`timescale 1ns/1ps
module tb_tx_rx_receiver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tx_rx_receiver_if #(.DATA_W(10), .CNT_W(8)) bus ();

    tx_rx_receiver #(.DATA_W(10), .CNT_W(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int c0;
    int exp_cnt  = 0;
    logic busy_e0, busy_end;

    int         vcyc_q[$];
    logic [9:0] vdata_q[$];
    int         ecyc_q[$];
    int         both_cnt = 0;

    // Edge counter
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse recorder, sampled on the falling edge
    always @(negedge clk) begin
        if (bus.o_valid) begin
            vcyc_q.push_back(cyc);
            vdata_q.push_back(bus.o_data);
        end
        if (bus.o_frame_err) ecyc_q.push_back(cyc);
        if (bus.o_valid && bus.o_frame_err) both_cnt++;
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Transmitter model: strobe sampled at E0, bit k presented for E(k+2), done at done_edge
    task automatic send_frame(input logic [9:0] d, input int done_edge,
                              input bit strobe_next, input bit skip_strobe);
        if (!skip_strobe) begin
            bus.i_rx_ena_n = 1'b0;
            @(negedge clk);
            bus.i_rx_ena_n = 1'b1;
        end
        c0 = cyc;
        busy_e0 = bus.o_busy;
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            bus.i_serial   = d[k];
            bus.i_tx_done  = (k + 2 == done_edge);
            bus.i_rx_ena_n = !(strobe_next && k == 9);
            @(negedge clk);
            if (k + 2 == done_edge && k != 9) break;
        end
        bus.i_tx_done  = 1'b0;
        bus.i_rx_ena_n = 1'b1;
        bus.i_serial   = 1'b0;
        busy_end = bus.o_busy;
    endtask

    task automatic clear_q();
        vcyc_q.delete();
        vdata_q.delete();
        ecyc_q.delete();
    endtask

    task automatic test_reset();
        bus.i_rx_ena_n = 1'b1;
        bus.i_serial   = 1'b0;
        bus.i_tx_done  = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.o_data !== 10'h000) begin n_fail++; $display("FAIL reset_data: got %h expected 000", bus.o_data); end
        n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.o_valid); end
        n_checks++; if (bus.o_frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus.o_frame_err); end
        n_checks++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.o_busy); end
        n_checks++; if (bus.o_frame_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", bus.o_frame_cnt); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", bus.o_busy); end
        exp_cnt = 0;
    endtask

    task automatic test_single();
        clear_q();
        send_frame(10'h2A5, 11, 1'b0, 1'b0);
        exp_cnt++;
        n_checks++; if (busy_e0 !== 1'b1) begin n_fail++; $display("FAIL single_busy_e0: got %b expected 1", busy_e0); end
        n_checks++; if (busy_end !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b expected 0", busy_end); end
        repeat (2) @(negedge clk);
        n_checks++; if (vcyc_q.size() != 1) begin n_fail++; $display("FAIL single_valid_count: got %0d expected 1", vcyc_q.size()); end
        n_checks++; if (vcyc_q.size() > 0 && vcyc_q[0] != c0 + 11) begin n_fail++; $display("FAIL single_latency: got %0d expected 11", vcyc_q[0] - c0); end
        n_checks++; if (bus.o_data !== 10'h2A5) begin n_fail++; $display("FAIL single_data: got %h expected 2a5", bus.o_data); end
        n_checks++; if (bus.o_frame_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL single_cnt: got %0d expected %0d", bus.o_frame_cnt, exp_cnt); end
        n_checks++; if (ecyc_q.size() != 0) begin n_fail++; $display("FAIL single_no_err: got %0d expected 0", ecyc_q.size()); end
    endtask

    task automatic test_back_to_back();
        clear_q();
        send_frame(10'h3FF, 11, 1'b1, 1'b0);
        n_checks++; if (busy_end !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_held: got %b expected 1", busy_end); end
        send_frame(10'h001, 11, 1'b0, 1'b1);
        exp_cnt += 2;
        repeat (2) @(negedge clk);
        n_checks++; if (vdata_q.size() != 2) begin n_fail++; $display("FAIL b2b_valid_count: got %0d expected 2", vdata_q.size()); end
        if (vdata_q.size() == 2) begin
            n_checks++; if (vdata_q[0] !== 10'h3FF) begin n_fail++; $display("FAIL b2b_data0: got %h expected 3ff", vdata_q[0]); end
            n_checks++; if (vdata_q[1] !== 10'h001) begin n_fail++; $display("FAIL b2b_data1: got %h expected 001", vdata_q[1]); end
            n_checks++; if (vcyc_q[1] - vcyc_q[0] != 11) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 11", vcyc_q[1] - vcyc_q[0]); end
        end
        n_checks++; if (bus.o_frame_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL b2b_cnt: got %0d expected %0d", bus.o_frame_cnt, exp_cnt); end
    endtask

    task automatic test_missing_done();
        clear_q();
        send_frame(10'h155, 0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        n_checks++; if (ecyc_q.size() != 1) begin n_fail++; $display("FAIL missing_err_count: got %0d expected 1", ecyc_q.size()); end
        n_checks++; if (ecyc_q.size() > 0 && ecyc_q[0] != c0 + 11) begin n_fail++; $display("FAIL missing_err_time: got %0d expected 11", ecyc_q[0] - c0); end
        n_checks++; if (vcyc_q.size() != 0) begin n_fail++; $display("FAIL missing_no_valid: got %0d expected 0", vcyc_q.size()); end
        n_checks++; if (bus.o_data !== 10'h001) begin n_fail++; $display("FAIL missing_data_held: got %h expected 001", bus.o_data); end
        n_checks++; if (bus.o_frame_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL missing_cnt: got %0d expected %0d", bus.o_frame_cnt, exp_cnt); end
    endtask

    task automatic test_early_done();
        clear_q();
        send_frame(10'h3C3, 5, 1'b0, 1'b0);
        n_checks++; if (busy_end !== 1'b0) begin n_fail++; $display("FAIL early_busy_drop: got %b expected 0", busy_end); end
        repeat (12) @(negedge clk);
        n_checks++; if (ecyc_q.size() != 1) begin n_fail++; $display("FAIL early_err_count: got %0d expected 1", ecyc_q.size()); end
        n_checks++; if (ecyc_q.size() > 0 && ecyc_q[0] != c0 + 5) begin n_fail++; $display("FAIL early_err_time: got %0d expected 5", ecyc_q[0] - c0); end
        n_checks++; if (vcyc_q.size() != 0) begin n_fail++; $display("FAIL early_no_valid: got %0d expected 0", vcyc_q.size()); end
        n_checks++; if (bus.o_frame_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL early_cnt: got %0d expected %0d", bus.o_frame_cnt, exp_cnt); end
        clear_q();
        send_frame(10'h0F0, 11, 1'b0, 1'b0);
        exp_cnt++;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.o_data !== 10'h0F0) begin n_fail++; $display("FAIL early_next_data: got %h expected 0f0", bus.o_data); end
        n_checks++; if (vcyc_q.size() != 1) begin n_fail++; $display("FAIL early_next_valid: got %0d expected 1", vcyc_q.size()); end
        n_checks++; if (bus.o_frame_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL early_next_cnt: got %0d expected %0d", bus.o_frame_cnt, exp_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] d;
        d = 10'h1B6;
        clear_q();
        bus.i_rx_ena_n = 1'b0;
        @(negedge clk);
        bus.i_rx_ena_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            bus.i_serial = d[k];
            @(negedge clk);
        end
        bus.i_serial = d[4];
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.o_data !== 10'h000) begin n_fail++; $display("FAIL rstmid_data: got %h expected 000", bus.o_data); end
        n_checks++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", bus.o_busy); end
        n_checks++; if (bus.o_frame_cnt !== 8'd0) begin n_fail++; $display("FAIL rstmid_cnt: got %0d expected 0", bus.o_frame_cnt); end
        exp_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 6; k < 10; k++) begin
            bus.i_serial  = d[k];
            bus.i_tx_done = (k == 9);
            @(negedge clk);
        end
        bus.i_tx_done = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (vcyc_q.size() != 0 || ecyc_q.size() != 0) begin n_fail++; $display("FAIL rstmid_no_pulse: got %0d/%0d pulses expected 0/0", vcyc_q.size(), ecyc_q.size()); end
        n_checks++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got %b expected 0", bus.o_busy); end
        send_frame(10'h2AA, 11, 1'b0, 1'b0);
        exp_cnt++;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.o_data !== 10'h2AA) begin n_fail++; $display("FAIL rstmid_next_data: got %h expected 2aa", bus.o_data); end
        n_checks++; if (bus.o_frame_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL rstmid_next_cnt: got %0d expected %0d", bus.o_frame_cnt, exp_cnt); end
    endtask

    task automatic test_counter_wrap();
        while (exp_cnt < 255) begin
            send_frame(10'(exp_cnt * 7 + 3), 11, 1'b0, 1'b0);
            exp_cnt++;
        end
        repeat (2) @(negedge clk);
        n_checks++; if (bus.o_frame_cnt !== 8'd255) begin n_fail++; $display("FAIL wrap_255: got %0d expected 255", bus.o_frame_cnt); end
        send_frame(10'h3A5, 11, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        n_checks++; if (bus.o_frame_cnt !== 8'd0) begin n_fail++; $display("FAIL wrap_0: got %0d expected 0", bus.o_frame_cnt); end
        n_checks++; if (bus.o_data !== 10'h3A5) begin n_fail++; $display("FAIL wrap_data: got %h expected 3a5", bus.o_data); end
        send_frame(10'h05A, 11, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        n_checks++; if (bus.o_frame_cnt !== 8'd1) begin n_fail++; $display("FAIL wrap_1: got %0d expected 1", bus.o_frame_cnt); end
        n_checks++; if (both_cnt != 0) begin n_fail++; $display("FAIL valid_err_exclusive: got %0d overlaps expected 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_missing_done();
        test_early_done();
        test_reset_mid_frame();
        test_counter_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_rx_receiver.md
# tx_rx_receiver

Serial receiver for the 10-bit LSB-first link driven by the team's transmitter block. It sits on the far end of the `o_serial` / `o_tx_done` wires and shares the same `i_clk`. It also observes the same active-low start strobe that launches the transmitter. It deserialises each frame, checks framing against the transmitter's done pulse, presents the word with a one-cycle valid pulse, and keeps a running count of good frames.

## Interface
- `DATA_W`, 10, frame width in bits; must match the transmitter.
- `CNT_W`, 8, width of the good-frame counter.

Ports:
- `i_clk` input 1: single clock, rising edge, shared with the transmitter.
- `i_rst_n` input 1: reset, asynchronous assert, active-low; everything clears on assertion.
- `i_rx_ena_n` input 1: active-low start strobe; the same net that drives the transmitter's `i_tx_ena_n`.
- `i_serial` input 1: serial data from the transmitter's `o_serial`.
- `i_tx_done` input 1: the transmitter's `o_tx_done`, used as the end-of-frame marker.
- `o_data` output DATA_W: last good received word, held until the next good frame.
- `o_valid` output 1: one-cycle pulse when `o_data` updates.
- `o_frame_err` output 1: one-cycle pulse on a framing error.
- `o_busy` output 1: high while in ALIGN or SHIFT.
- `o_frame_cnt` output CNT_W: number of good frames, modulo 2^CNT_W.

## Operation
- There are three states: IDLE, ALIGN and SHIFT. A 4-bit bit counter `bit_cnt` and a DATA_W shift register support them.
- IDLE:
  - If `i_rx_ena_n`=0 at an edge, go to ALIGN.
  - Otherwise stay in IDLE.
- ALIGN: always go to SHIFT at the next edge and set `bit_cnt`=0. This matches the transmitter's one-cycle load latency.
- SHIFT: at each edge, shift in with `sreg <= {i_serial, sreg[DATA_W-1:1]}`, so the first bit lands at the LSB. Then increment `bit_cnt`.
- Last sample is the edge where `bit_cnt`==DATA_W-1:
  - If `i_tx_done`=1: latch `o_data` <= `{i_serial, sreg[DATA_W-1:1]}`, pulse `o_valid`, and increment `o_frame_cnt`.
  - If `i_tx_done`=0: pulse `o_frame_err`. `o_data` and the count are unchanged.
  - Next state is ALIGN if `i_rx_ena_n`=0 at this same edge (back-to-back frame). Otherwise it is IDLE.
- Early done: if `i_tx_done`=1 at any SHIFT edge with `bit_cnt`<DATA_W-1:
  - Abort the frame and pulse `o_frame_err`.
  - Go to IDLE. `o_data` and the count are unchanged.
- `i_rx_ena_n` is ignored in ALIGN, and in SHIFT except at the last-sample edge.
- `o_frame_cnt` wraps from 2^CNT_W-1 to 0 without saturating.
- `o_valid` and `o_frame_err` are never high together.

## Timing
- Reset values:
  - `o_data`=0, `o_valid`=0, `o_frame_err`=0, `o_busy`=0, `o_frame_cnt`=0.
  - State is IDLE; `bit_cnt` and `sreg` are 0.
- Reset mid-frame: the frame is discarded with no valid or error pulse. Reception restarts only on a fresh strobe after `i_rst_n` deasserts.
- Cycle alignment, with E0 being the edge where the strobe is sampled low in IDLE:
  - E1 enters SHIFT.
  - Bit k is sampled at E(k+2), so bit 0 is sampled at E2 and bit 9 at E11.
  - `i_tx_done` is checked at E11.
- Latency: `o_valid` is high in the cycle after E11, which is 11 edges after the strobe.
- `o_busy` is high from after E0 through E11. It drops after E11 unless a back-to-back strobe is accepted.
- Back-to-back: a strobe at E11 gives the next frame's bit 0 sampled at E13, with no gap cycle lost.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Single frame: drive the transmitter with 10'h2A5 via one strobe → `o_data`=10'h2A5, a single `o_valid` pulse after E11, `o_frame_cnt`=1, `o_frame_err` never high.
- Back-to-back: strobe 10'h3FF, then strobe again at E11 with 10'h001 → two `o_valid` pulses 11 cycles apart, `o_data` 10'h3FF then 10'h001, `o_frame_cnt`=2.
- Missing done: force `i_tx_done`=0 for a 10'h155 frame → `o_frame_err` pulse after E11, `o_data` keeps its old value, count unchanged.
- Early done: force `i_tx_done`=1 at E5 → `o_frame_err` pulse after E5, `o_busy` drops, and a following good 10'h0F0 frame is received correctly.
- Reset mid-frame: assert `i_rst_n`=0 at E6 → all outputs are 0 immediately (asynchronous), no pulses, and the next strobed 10'h2AA is received correctly.
- Counter wrap: send 256 good frames with CNT_W=8 → `o_frame_cnt` reads 255, then 0, and the 257th frame gives 1.
